uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver with its own bit-timing counter; it needs no external baud generator or start handshake. Configurable data width, parity mode and stop-bit count. Uses a 3-sample majority vote at mid-bit and reports framing, parity and overrun errors. Delivers each character through a valid/ready holding register to the MCU-side logic on the same clock domain.

Parameters:
CLK_DIV, 174, clocks per bit (20 MHz / 115200); legal range 8..65535
DATA_BITS, 8, data bits per character; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock (20 MHz)
rst  in  1  reset, asynchronous, active-high
rxd  in  1  serial line; idle high; asynchronous to clk
rx_data  out  DATA_BITS  received character, LSB first on the wire
rx_valid  out  1  rx_data, frame_err and parity_err are valid; held until accepted
rx_ready  in  1  consumer accepts the character when rx_valid && rx_ready
frame_err  out  1  stop bit sampled low for this character
parity_err  out  1  parity mismatch for this character; always 0 when PARITY = 0
overrun  out  1  one-cycle pulse when a completed character is dropped
rx_busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, synchroniser flops = 1, counters 0.
- Input path: 2-flop synchroniser on rxd, then a 3-deep history. Falling edge is detected on the synchronised line.
- Bit counter: counts 0..CLK_DIV-1 and wraps. Midpoint M = CLK_DIV/2 (integer division).
- Majority vote: the bit value is the majority of synchronised samples at counts M-1, M and M+1. The decision is registered at count M+1.
- State machine:
  - IDLE: on a falling edge, go to START with counter = 0; rx_busy = 1.
  - START: at the majority decision, a 1 is a false start; go to IDLE with no output. A 0 goes to DATA with bit index = 0.
  - DATA: at each decision, shift the bit in LSB first. After DATA_BITS bits, go to PARITY if PARITY != 0, otherwise to STOP.
  - PARITY: compare the sampled bit with the computed parity (odd: data XOR parity bit = 1; even: = 0). Latch any mismatch.
  - STOP: sample STOP_BITS stop bits. Any stop bit sampled 0 sets frame_err_pending. After the last stop decision, the character completes. Go to IDLE if the line is high, otherwise to BREAK.
  - BREAK: wait for the synchronised line = 1, then go to IDLE. No further characters are produced during a break.
- Completion, on the cycle after the last stop decision:
  - If rx_valid = 0, or rx_valid && rx_ready in that same cycle: load rx_data, frame_err and parity_err; rx_valid = 1.
  - Otherwise: drop the new character, keep the held character unchanged, and pulse overrun for 1 cycle.
- Handshake: rx_valid falls on the cycle after acceptance unless a new completion coincides with it; in that case rx_valid stays 1 with the new data. rx_data and the error flags are stable while rx_valid = 1.
- Latency: rxd falling edge to rx_valid is 2 sync cycles + (1 + DATA_BITS + P + STOP_BITS - 1) × CLK_DIV + M + 2 clocks, where P = 1 if parity is enabled, otherwise 0.
- Error priority: none. frame_err and parity_err may both be 1.
- Break condition (line low for the whole frame): delivered once as data 0 with frame_err = 1, then the receiver waits in BREAK.
- Re-arm: the receiver re-arms in IDLE, so a start bit that begins during the second half of the last stop bit is still detected once IDLE is re-entered.
- rx_busy deasserts on entry to IDLE, including after a false start.

Decomposition:
- Shared package uart_pkg: PARITY_NONE/ODD/EVEN encodings, state encodings (IDLE, START, DATA, PARITY, STOP, BREAK), and a default CLK_DIV localparam for 20 MHz / 115200. The package is shared with a future parametrised transmitter.
- One sub-module, uart_rx_sampler: synchroniser, bit counter and 3-sample majority. Outputs are a falling-edge strobe, a bit_tick strobe and bit_value. The FSM, output register and handshake stay in the top level.

Test Plan:
- CLK_DIV = 16, 8N1, rx_ready = 1. Send 0xA5 → one rx_valid with rx_data = 0xA5, frame_err = 0, parity_err = 0. Valid asserts at the computed latency ±0 clocks.
- PARITY = 2 (even). Send 0x03 with parity bit 1 → rx_data = 0x03, parity_err = 1. Resend with parity bit 0 → parity_err = 0.
- Glitch: rxd low for 4 clocks (< M), then high → no rx_valid; rx_busy returns to 0 within CLK_DIV clocks.
- rx_ready = 0. Send 0x11 then 0x22 back-to-back → rx_data stays 0x11, one overrun pulse. After rx_ready = 1, rx_valid drops and no 0x22 appears.
- Break: rxd low for 20 bit times, then high → exactly one character, 0x00 with frame_err = 1. A following 0x5A is received correctly.
- Reset mid-frame: assert rst during bit 3 of 0xFF → outputs 0 immediately (asynchronous). After release and an idle line, 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver states, default bit timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 20 MHz / 115200 baud = 173.6 clocks per bit, rounded up.
  localparam int CLK_DIV_DEFAULT = 174;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Character delivery bundle between the UART receiver and its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer drives rx_ready; the receiver holds rx_data/flags while rx_valid.
// Ports: master = receiver (drives data, flags, status), slave = consumer (drives rx_ready).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 rx_busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, rx_busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: rxd synchroniser, bit-period counter, 3-sample majority vote.
// Latency: 2 clocks rxd->line_o; bit_tick_o fires in the cycle where the counter sits at M+1.
// Backpressure: none; cnt_run_i low parks the counter at 0.
// Ports: clk/rst, rxd_i (async line), cnt_run_i (counter enable from FSM),
//        fall_o (falling edge on synced line), bit_tick_o (decision strobe),
//        bit_value_o (majority of samples at M-1, M, M+1), line_o (synced line).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd_i,
  input  logic cnt_run_i,
  output logic fall_o,
  output logic bit_tick_o,
  output logic bit_value_o,
  output logic line_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(CLK_DIV / 2 + 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    hist_q;   // hist_q[0] = line one cycle ago, hist_q[1] = two cycles ago
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (cnt_run_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 2'b11;
      cnt_q   <= '0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[0], sync2_q};
      cnt_q   <= cnt_d;
    end
  end

  assign line_o      = sync2_q;
  assign fall_o      = hist_q[0] & ~sync2_q;
  // At count M+1 the current sample plus the two history flops cover counts M-1..M+1.
  assign bit_tick_o  = (cnt_q == CNT_DEC);
  assign bit_value_o = maj3(sync2_q, hist_q[0], hist_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with framing/parity/overrun reporting and a holding register.
// Latency: rxd fall to rx_valid = 2 + (DATA_BITS+P+STOP_BITS)*CLK_DIV + CLK_DIV/2 + 2 clocks.
// Backpressure: one-deep holding register; a character completing while it is full and not accepted is dropped with an overrun pulse.
// Ports: clk, rst (async, active-high), rxd (serial line, idle high),
//        rx_if.master (rx_data/rx_valid/rx_ready handshake, frame_err, parity_err, overrun, rx_busy).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  uart_rx_param_if.master rx_if
);
  localparam logic [3:0] IDX_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] IDX_LAST_STOP = 4'(STOP_BITS - 1);

  logic fall, bit_tick, bit_value, line, cnt_run, complete;

  rx_state_e            state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;

  uart_rx_sampler #(.CLK_DIV(CLK_DIV)) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rxd_i       (rxd),
    .cnt_run_i   (cnt_run),
    .fall_o      (fall),
    .bit_tick_o  (bit_tick),
    .bit_value_o (bit_value),
    .line_o      (line)
  );

  // Frame sequencing
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    cnt_run   = 1'b1;
    complete  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The fall cycle is count 0, so the counter starts moving right away.
        cnt_run = fall;
        if (fall) begin
          state_d   = ST_START;
          bit_idx_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = bit_value ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shreg_d = {bit_value, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          perr_d  = (^{shreg_q, bit_value}) != (PARITY == PARITY_ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (!bit_value) ferr_d = 1'b1;
          if (bit_idx_q == IDX_LAST_STOP) begin
            complete = 1'b1;
            state_d  = bit_value ? ST_IDLE : ST_BREAK;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        cnt_run = 1'b0;
        if (line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: a completion may reuse the slot in the same cycle it is accepted.
  always_comb begin
    data_d  = data_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    valid_d = valid_q & ~rx_if.rx_ready;
    ovr_d   = 1'b0;
    if (complete) begin
      if (!valid_q || rx_if.rx_ready) begin
        data_d  = shreg_q;
        fe_d    = ferr_d;   // includes the stop bit being decided this cycle
        pe_d    = perr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.parity_err = pe_q;
  assign rx_if.overrun    = ovr_q;
  assign rx_if.rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 and 8E1 receivers at 16 clocks per bit.
// Latency: n/a.
// Backpressure: rx_ready driven directly by the stimulus.
module tb_uart_rx_param;
  localparam int CD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifb ();

  uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rx_if(ifa)
  );
  uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rx_if(ifb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         rise;
  } cap_t;

  typedef struct {
    bit         sel;      // 0 = 8N1 receiver, 1 = 8E1 receiver
    logic [7:0] data;
    logic       pbit;
    logic       stopv;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  cap_t qa[$];
  cap_t qb[$];
  int   cyc = 0;
  int   rise_a = 0, rise_b = 0;
  int   ovr_a = 0;
  int   fall_cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Capture every accepted character and the cycle its rx_valid rose.
  initial begin
    logic pva, pvb;
    cap_t c;
    pva = 1'b0;
    pvb = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.rx_valid && !pva) rise_a = cyc;
      if (ifb.rx_valid && !pvb) rise_b = cyc;
      pva = ifa.rx_valid;
      pvb = ifb.rx_valid;
      if (ifa.rx_valid && ifa.rx_ready) begin
        c.data = ifa.rx_data; c.fe = ifa.frame_err; c.pe = ifa.parity_err; c.rise = rise_a;
        qa.push_back(c);
      end
      if (ifb.rx_valid && ifb.rx_ready) begin
        c.data = ifb.rx_data; c.fe = ifb.frame_err; c.pe = ifb.parity_err; c.rise = rise_b;
        qb.push_back(c);
      end
      if (ifa.overrun) ovr_a++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_rxd(input bit sel, input logic v);
    if (sel) rxd_b = v; else rxd_a = v;
  endtask

  // One bit time: change the line just after a rising edge, then hold for CD clocks.
  task automatic drive_bit(input bit sel, input logic v);
    @(posedge clk);
    #1;
    set_rxd(sel, v);
    repeat (CD - 1) @(posedge clk);
  endtask

  task automatic idle_bits(input bit sel, input int n);
    @(posedge clk);
    #1;
    set_rxd(sel, 1'b1);
    repeat (n * CD - 1) @(posedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic pb, input logic stopv);
    @(posedge clk);
    #1;
    set_rxd(sel, 1'b0);
    fall_cyc = cyc;
    repeat (CD - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, pb);
    drive_bit(sel, stopv);
  endtask

  task automatic expect_char(input string nm, input bit sel, input logic [7:0] d,
                             input logic fe, input logic pe, input int lat);
    cap_t c;
    int   sz;
    sz = sel ? qb.size() : qa.size();
    check({nm, "_count"}, sz, 1);
    if (sz > 0) begin
      c = sel ? qb.pop_front() : qa.pop_front();
      check({nm, "_data"}, {24'd0, c.data}, {24'd0, d});
      check({nm, "_ferr"}, {31'd0, c.fe}, {31'd0, fe});
      check({nm, "_perr"}, {31'd0, c.pe}, {31'd0, pe});
      if (lat > 0) check({nm, "_latency"}, c.rise - fall_cyc, lat);
    end
    if (sel) qb.delete(); else qa.delete();
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    int ovr0;
    int drop_cyc;
    bit saw_busy;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    vecs[5] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[8] = '{1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};

    ifa.rx_ready = 1'b1;
    ifb.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", {31'd0, ifa.rx_valid}, 0);
    check("rst_data_a", {24'd0, ifa.rx_data}, 0);
    check("rst_busy_a", {31'd0, ifa.rx_busy}, 0);
    check("rst_ferr_a", {31'd0, ifa.frame_err}, 0);
    check("rst_perr_a", {31'd0, ifa.parity_err}, 0);
    check("rst_ovr_a", {31'd0, ifa.overrun}, 0);
    check("rst_valid_b", {31'd0, ifb.rx_valid}, 0);
    check("rst_busy_b", {31'd0, ifb.rx_busy}, 0);
    rst = 1'b0;
    idle_bits(0, 2);

    // Table-driven frames; latency = 2 sync + (bits after start)*CD + CD/2 + 2.
    for (int v = 0; v < 9; v++) begin
      lat = 2 + (1 + 8 + (vecs[v].sel ? 1 : 0) + 1 - 1) * CD + CD / 2 + 2;
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].sel, vecs[v].pbit, vecs[v].stopv);
      idle_bits(vecs[v].sel, 2);
      expect_char($sformatf("vec%0d", v), vecs[v].sel, vecs[v].exp_data,
                  vecs[v].exp_fe, vecs[v].exp_pe, lat);
    end

    // Glitch shorter than half a bit: false start, no character.
    @(posedge clk);
    #1;
    rxd_a = 1'b0;
    fall_cyc = cyc;
    saw_busy = 1'b0;
    drop_cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) rxd_a = 1'b1;
      if (ifa.rx_busy) saw_busy = 1'b1;
      if (saw_busy && !ifa.rx_busy && drop_cyc < 0) drop_cyc = cyc;
    end
    check("glitch_busy_seen", {31'd0, saw_busy}, 1);
    check("glitch_busy_drop", {31'd0, (drop_cyc >= 0) && (drop_cyc - fall_cyc <= CD)}, 1);
    idle_bits(0, 2);
    check("glitch_no_char", qa.size(), 0);

    // Overrun: second character dropped while the first is held.
    ifa.rx_ready = 1'b0;
    ovr0 = ovr_a;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1);
    idle_bits(0, 2);
    check("ovr_held_valid", {31'd0, ifa.rx_valid}, 1);
    check("ovr_held_data", {24'd0, ifa.rx_data}, 32'h11);
    check("ovr_pulses", ovr_a - ovr0, 1);
    @(posedge clk);
    #1;
    ifa.rx_ready = 1'b1;
    idle_bits(0, 1);
    check("ovr_valid_drop", {31'd0, ifa.rx_valid}, 0);
    expect_char("ovr_accept", 0, 8'h11, 1'b0, 1'b0, 0);

    // Break: one zero character with framing error, then normal reception.
    @(posedge clk);
    #1;
    rxd_a = 1'b0;
    repeat (20 * CD) @(posedge clk);
    idle_bits(0, 2);
    expect_char("break", 0, 8'h00, 1'b1, 1'b0, 0);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    idle_bits(0, 2);
    expect_char("after_break", 0, 8'h5A, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of a frame while a character is held.
    ifa.rx_ready = 1'b0;
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    idle_bits(0, 2);
    check("prerst_valid", {31'd0, ifa.rx_valid}, 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    @(posedge clk);
    #1;
    rxd_a = 1'b1;
    repeat (5) @(posedge clk);
    check("prerst_busy", {31'd0, ifa.rx_busy}, 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, ifa.rx_valid}, 0);
    check("arst_data", {24'd0, ifa.rx_data}, 0);
    check("arst_busy", {31'd0, ifa.rx_busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ifa.rx_ready = 1'b1;
    idle_bits(0, 2);
    check("postrst_no_char", qa.size(), 0);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    idle_bits(0, 2);
    expect_char("postrst", 0, 8'h3C, 1'b0, 1'b0, 2 + 9 * CD + CD / 2 + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
